hilo_div_ctrl: RTL and testbench
================================

# hilo_div_ctrl

Sequencer between the CPU's EX stage and the 32-cycle iterative divider. It accepts DIV/DIVU/MTHI/MTLO/MFHI/MFLO, converts signed operands to magnitudes, issues them to the divider, sign-corrects the results and commits them to HI/LO. It interlocks any HI/LO access that arrives while a divide is in flight. A flushed divide is drained and discarded.

## Interface
- WIDTH, 32, datapath width; the divider must match.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low; shared with the divider.
- op_valid  in  1  EX-stage HI/LO operation present.
- op_code  in  3  0 DIV, 1 DIVU, 2 MTHI, 3 MTLO, 4 MFHI, 5 MFLO; 6/7 no-op.
- rs_data  in  WIDTH  dividend / MT source.
- rt_data  in  WIDTH  divisor.
- flush  in  1  squash the in-flight divide and any op presented this cycle.
- stall  out  1  pipeline must hold the presented op.
- rd_data  out  WIDTH  MFHI/MFLO result.
- rd_valid  out  1  rd_data valid (1-cycle pulse).
- div_zero  out  1  1-cycle pulse: divide by zero accepted.
- hi, lo  out  WIDTH  architectural HI/LO registers.
- div_in_valid  out  1  divider start pulse.
- div_dividend, div_divisor  out  WIDTH  unsigned operands to divider.
- div_quotient, div_remainder  in  WIDTH  divider results.
- div_out_valid  in  1  divider result pulse.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, DRAIN. busy = (state != IDLE).
- An op is "accepted" when op_valid & ~stall & ~flush & op_code<=5, in IDLE only.
- stall = op_valid & (op_code<=5) & busy. This is combinational; ops 6/7 are never stalled.
- IDLE, DIV/DIVU, rt_data != 0: latch |rs|, |rt| (DIV) or raw values (DIVU). Latch neg_q = sign(rs)^sign(rt) and neg_r = sign(rs) (DIV only; both 0 for DIVU). Next state ISSUE.
- IDLE, DIV/DIVU, rt_data == 0: no divider issue. At the edge HI<=rs_data, LO<={WIDTH{1}}. div_zero=1 in the accept cycle. Stay in IDLE.
- IDLE, MTHI/MTLO: HI or LO <= rs_data at the edge.
- IDLE, MFHI/MFLO: rd_data<=HI or LO at the edge. rd_valid=1 the following cycle.
- ISSUE: div_in_valid=1 for exactly one cycle, with operands from the latch. Next state WAIT; DRAIN if flush.
- WAIT: hold until div_out_valid, then capture quotient/remainder and go to WRITE. flush -> DRAIN.
- WRITE: LO <= neg_q ? -q : q and HI <= neg_r ? -r : r (two's complement, WIDTH bits). Next state IDLE.
- DRAIN: wait for div_out_valid, discard the result; HI/LO unchanged. Next state IDLE.
- Overflow -2^31 / -1 (DIV): LO=0x80000000, HI=0. This is not an error.
- div_dividend/div_divisor hold the latched values from ISSUE through WAIT.
- div_out_valid outside WAIT/DRAIN is ignored.

## Timing
- Reset: state IDLE; hi, lo, rd_data = 0; rd_valid, div_zero, div_in_valid = 0; latches cleared.
- Reset mid-divide returns to IDLE immediately, with HI/LO = 0.
- Accept cycle N → div_in_valid at N+1.
- With the 32-iteration divider, div_out_valid arrives at N+34 and WRITE occurs at N+35. HI/LO are visible from N+36, the first cycle an MFHI can be accepted.
- A dependent HI/LO op presented during N+1..N+35 sees stall=1 every cycle.
- Non-divide ops in IDLE take one cycle with no stall.
- MFHI accepted at cycle M → rd_valid and rd_data at M+1.
- flush has priority over acceptance in the same cycle.
- flush in IDLE with no divide in flight has no effect on HI/LO.

## Test plan
- DIVU rs=100, rt=7 → div_in_valid one cycle after accept. After div_out_valid: LO=14, HI=2, IDLE two cycles later.
- DIV rs=-7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIV rs=7, rt=-2 → LO=-3, HI=1.
- DIV rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0. DIVU rs=5, rt=0 → div_zero pulse, HI=5, LO=0xFFFFFFFF, no div_in_valid, no busy.
- DIVU 100/7, then MFLO held at op_valid=1 → stall=1 each cycle until WRITE has completed. MFLO accepted the next cycle; rd_valid with rd_data=14 one cycle later. Opcode-6 ops during the divide are never stalled.
- DIVU 100/7, then flush in WAIT → state DRAIN, divider result discarded, HI/LO keep their prior MTHI/MTLO values (0x1234/0x5678).
- Assert rst_n=0 asynchronously in WAIT → all outputs 0 without a clock edge. After release, MTHI 0xAAAA then MFHI → rd_data=0xAAAA.

Source files
------------

// File: rtl/hilo_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl_if : start/result handshake between HI/LO control and divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_in_valid;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             div_out_valid;

  modport master (
    output div_in_valid, div_dividend, div_divisor,
    input  div_quotient, div_remainder, div_out_valid
  );

  modport slave (
    input  div_in_valid, div_dividend, div_divisor,
    output div_quotient, div_remainder, div_out_valid
  );
endinterface

`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_div_ctrl : EX-stage HI/LO sequencer with signed fix-up around an unsigned divider
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hilo_div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  input  logic [2:0]        op_code,
  input  logic [WIDTH-1:0]  rs_data,
  input  logic [WIDTH-1:0]  rt_data,
  input  logic              flush,
  output logic              stall,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              div_zero,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo,
  hilo_div_ctrl_if.master   div
);

  localparam logic [2:0] c_OP_DIV  = 3'd0;
  localparam logic [2:0] c_OP_DIVU = 3'd1;
  localparam logic [2:0] c_OP_MTHI = 3'd2;
  localparam logic [2:0] c_OP_MTLO = 3'd3;
  localparam logic [2:0] c_OP_MFHI = 3'd4;
  localparam logic [2:0] c_OP_MFLO = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_busy;
  logic             w_hilo_op;
  logic             w_accept;
  logic             w_is_div;
  logic             w_rt_zero;
  logic             w_start;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_mag;
  logic [WIDTH-1:0] w_rt_mag;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_hilo_op = (op_code <= c_OP_MFLO);
  assign stall     = op_valid & w_hilo_op & w_busy;
  // flush outranks acceptance so a squashed op never touches HI/LO
  assign w_accept  = op_valid & w_hilo_op & ~w_busy & ~flush;
  assign w_is_div  = (op_code == c_OP_DIV) | (op_code == c_OP_DIVU);
  assign w_rt_zero = (rt_data == '0);
  assign w_start   = w_accept & w_is_div & ~w_rt_zero;
  assign div_zero  = w_accept & w_is_div & w_rt_zero;

  // DIVU leaves both sign flags clear, so the magnitudes are the raw operands
  assign w_rs_neg  = (op_code == c_OP_DIV) & rs_data[WIDTH-1];
  assign w_rt_neg  = (op_code == c_OP_DIV) & rt_data[WIDTH-1];
  assign w_rs_mag  = w_rs_neg ? (-rs_data) : rs_data;
  assign w_rt_mag  = w_rt_neg ? (-rt_data) : rt_data;

  assign div.div_in_valid = (r_state == ST_ISSUE);
  assign div.div_dividend = r_dividend;
  assign div.div_divisor  = r_divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_ISSUE;
      ST_ISSUE: w_next = flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        // a result arriving with the flush is already drained
        if (flush)              w_next = div.div_out_valid ? ST_IDLE : ST_DRAIN;
        else if (div.div_out_valid) w_next = ST_WRITE;
      end
      ST_WRITE: w_next = ST_IDLE;
      ST_DRAIN: if (div.div_out_valid) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi         <= '0;
      lo         <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_q        <= '0;
      r_r        <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      rd_valid <= 1'b0;

      if (w_start) begin
        r_dividend <= w_rs_mag;
        r_divisor  <= w_rt_mag;
        r_neg_q    <= w_rs_neg ^ w_rt_neg;
        r_neg_r    <= w_rs_neg;
      end

      if ((r_state == ST_WAIT) && div.div_out_valid && !flush) begin
        r_q <= div.div_quotient;
        r_r <= div.div_remainder;
      end

      if (r_state == ST_WRITE) begin
        lo <= r_neg_q ? (-r_q) : r_q;
        hi <= r_neg_r ? (-r_r) : r_r;
      end

      if (w_accept) begin
        case (op_code)
          c_OP_DIV, c_OP_DIVU: begin
            if (w_rt_zero) begin
              hi <= rs_data;
              lo <= '1;
            end
          end
          c_OP_MTHI: hi <= rs_data;
          c_OP_MTLO: lo <= rs_data;
          c_OP_MFHI: begin
            rd_data  <= hi;
            rd_valid <= 1'b1;
          end
          c_OP_MFLO: begin
            rd_data  <= lo;
            rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hilo_div_ctrl : directed bench with a 32-iteration divider model and rd_data scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hilo_div_ctrl;
  localparam int W = 32;
  localparam logic [2:0] DIV = 3'd0, DIVU = 3'd1, MTHI = 3'd2, MTLO = 3'd3,
                         MFHI = 3'd4, MFLO = 3'd5, NOP = 3'd6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          op_valid = 1'b0;
  logic [2:0]    op_code = 3'd7;
  logic [W-1:0]  rs_data = '0;
  logic [W-1:0]  rt_data = '0;
  logic          flush = 1'b0;
  logic          stall, rd_valid, div_zero;
  logic [W-1:0]  rd_data, hi, lo;

  hilo_div_ctrl_if #(.WIDTH(W)) dif ();

  hilo_div_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .flush    (flush),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo),
    .div      (dif)
  );

  always #5 clk = ~clk;

  // Divider model: result pulse 33 cycles after the start pulse
  logic [W-1:0] m_a, m_b;
  int           m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_a <= '0; m_b <= '0;
      dif.div_out_valid <= 1'b0;
      dif.div_quotient  <= '0;
      dif.div_remainder <= '0;
    end else begin
      dif.div_out_valid <= 1'b0;
      if (dif.div_in_valid) begin
        m_a <= dif.div_dividend; m_b <= dif.div_divisor; m_cnt <= 32;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          dif.div_out_valid <= 1'b1;
          dif.div_quotient  <= m_a / m_b;
          dif.div_remainder <= m_a % m_b;
        end
      end
    end
  end

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_q [$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every rd_valid pulse consumes one expected value
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        if (exp_q.size() == 0) check("rd_unexpected", {31'd0, rd_valid}, '0);
        else                   check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    op_valid = 1'b1; op_code = op; rs_data = rs; rt_data = rt; #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
    int n = 0;
    drive(op, rs, rt);
    while (stall && n < 200) begin tick; n++; end
    if (n >= 200) check("stall_timeout", {31'd0, stall}, '0);
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 3'd7;
  endtask

  task automatic mf(input logic [2:0] op, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    do_op(op, '0, '0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick;
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_valid", {31'd0, rd_valid}, '0);
    check("rst_div_in_valid", {31'd0, dif.div_in_valid}, '0);

    // DIVU 100/7 with issue timing and interlock length
    do_op(DIVU, 32'd100, 32'd7);
    check("issue_pulse", {31'd0, dif.div_in_valid}, 32'd1);
    check("issue_dividend", dif.div_dividend, 32'd100);
    check("issue_divisor", dif.div_divisor, 32'd7);
    tick;
    check("issue_one_cycle", {31'd0, dif.div_in_valid}, '0);
    drive(NOP, '0, '0);
    check("nop_no_stall", {31'd0, stall}, '0);
    drive(MFLO, '0, '0);
    n = 0;
    while (stall && n < 100) begin tick; n++; end
    check("stall_cycles", n, 32'd34);
    exp_q.push_back(32'd14);
    tick;
    op_valid = 1'b0; op_code = 3'd7;
    mf(MFHI, 32'd2);

    // Signed fix-up and overflow
    do_op(DIV, 32'hFFFF_FFF9, 32'd2);
    mf(MFLO, 32'hFFFF_FFFD);
    mf(MFHI, 32'hFFFF_FFFF);
    do_op(DIV, 32'd7, 32'hFFFF_FFFE);
    mf(MFLO, 32'hFFFF_FFFD);
    mf(MFHI, 32'd1);
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    mf(MFLO, 32'h8000_0000);
    mf(MFHI, 32'd0);

    // Divide by zero
    drive(DIVU, 32'd5, 32'd0);
    check("dz_pulse", {31'd0, div_zero}, 32'd1);
    check("dz_no_stall", {31'd0, stall}, '0);
    tick;
    op_valid = 1'b0; op_code = 3'd7; #1;
    check("dz_pulse_end", {31'd0, div_zero}, '0);
    check("dz_no_issue", {31'd0, dif.div_in_valid}, '0);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    drive(MFHI, '0, '0);
    check("dz_not_busy", {31'd0, stall}, '0);
    mf(MFHI, 32'd5);

    // Flush in WAIT drains the result
    do_op(MTHI, 32'h1234, '0);
    do_op(MTLO, 32'h5678, '0);
    do_op(DIVU, 32'd100, 32'd7);
    repeat (5) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive(MFHI, '0, '0);
    check("drain_busy", {31'd0, stall}, 32'd1);
    mf(MFHI, 32'h1234);
    mf(MFLO, 32'h5678);

    // Flush in IDLE squashes the presented op
    drive(MTHI, 32'hDEAD, '0);
    flush = 1'b1;
    tick;
    flush = 1'b0; op_valid = 1'b0; op_code = 3'd7;
    mf(MFHI, 32'h1234);

    // Asynchronous reset in WAIT
    do_op(DIVU, 32'd100, 32'd7);
    repeat (5) tick;
    #2 rst_n = 1'b0;
    drive(MFHI, '0, '0);
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    check("arst_rd_data", rd_data, '0);
    check("arst_div_in_valid", {31'd0, dif.div_in_valid}, '0);
    check("arst_idle", {31'd0, stall}, '0);
    op_valid = 1'b0; op_code = 3'd7;
    tick;
    #2 rst_n = 1'b1;
    tick;
    do_op(MTHI, 32'hAAAA, '0);
    mf(MFHI, 32'hAAAA);

    repeat (3) tick;
    check("queue_empty", exp_q.size(), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
